// File: rtl/collision_scheduler_if.sv
// ============================================================================
// Module   : collision_scheduler_if
// Function : Frame-tick request, snapshot inputs and scan results of the
//            time-multiplexed collision scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface collision_scheduler_if #(
  parameter int N_OBSTACLES = 4,
  parameter int X_BITWIDTH  = 8,
  parameter int Y_BITWIDTH  = 9
) ();
  logic                              start;
  logic                              clear;
  logic [X_BITWIDTH-1:0]             player_x;
  logic [Y_BITWIDTH-1:0]             player_y;
  logic [N_OBSTACLES*X_BITWIDTH-1:0] obstacle_x;
  logic [N_OBSTACLES*Y_BITWIDTH-1:0] obstacle_y;
  logic [N_OBSTACLES-1:0]            obstacle_active;
  logic                              busy;
  logic                              done;
  logic [N_OBSTACLES-1:0]            hit_mask;
  logic                              collision;

  modport master (
    output start, clear, player_x, player_y, obstacle_x, obstacle_y, obstacle_active,
    input  busy, done, hit_mask, collision
  );

  modport slave (
    input  start, clear, player_x, player_y, obstacle_x, obstacle_y, obstacle_active,
    output busy, done, hit_mask, collision
  );
endinterface

`default_nettype wire

// File: rtl/collision_scheduler.sv
// ============================================================================
// Module   : collision_scheduler
// Function : Snapshots player/obstacle positions on a frame tick and checks
//            one obstacle per clock with a single shared bounding-box test.
// Revision : 1.0
// ============================================================================
`default_nettype none

module collision_scheduler #(
  parameter int N_OBSTACLES     = 4,
  parameter int X_BITWIDTH      = 8,
  parameter int Y_BITWIDTH      = 9,
  parameter int PLAYER_WIDTH    = 32,
  parameter int PLAYER_HEIGHT   = 50,
  parameter int OBSTACLE_WIDTH  = 32,
  parameter int OBSTACLE_HEIGHT = 50
) (
  input  logic                  clock,
  input  logic                  reset,
  collision_scheduler_if.slave  bus
);

  localparam int IDX_W = (N_OBSTACLES > 1) ? $clog2(N_OBSTACLES) : 1;
  // Sums carry extra headroom so position + extent can never wrap.
  localparam int XS_W  = X_BITWIDTH + $clog2(PLAYER_HEIGHT + OBSTACLE_HEIGHT + 1) + 1;
  localparam int YS_W  = Y_BITWIDTH + $clog2(PLAYER_WIDTH + OBSTACLE_WIDTH + 1) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBSTACLES - 1);
  localparam logic [XS_W-1:0]  PH_E     = XS_W'(PLAYER_HEIGHT);
  localparam logic [XS_W-1:0]  OH_E     = XS_W'(OBSTACLE_HEIGHT);
  localparam logic [YS_W-1:0]  PW_E     = YS_W'(PLAYER_WIDTH);
  localparam logic [YS_W-1:0]  OW_E     = YS_W'(OBSTACLE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  index_q, index_d;
  logic [X_BITWIDTH-1:0]             px_q, px_d;
  logic [Y_BITWIDTH-1:0]             py_q, py_d;
  logic [N_OBSTACLES*X_BITWIDTH-1:0] ox_q, ox_d;
  logic [N_OBSTACLES*Y_BITWIDTH-1:0] oy_q, oy_d;
  logic [N_OBSTACLES-1:0]            act_q, act_d;
  logic [N_OBSTACLES-1:0]            work_q, work_d;
  logic [N_OBSTACLES-1:0]            hit_mask_q, hit_mask_d;
  logic                              done_q, done_d;
  logic                              collision_q, collision_d;

  logic [XS_W-1:0] px_e, ox_e;
  logic [YS_W-1:0] py_e, oy_e;
  logic            hit;

  // Shared comparator operating on the currently indexed snapshot slot.
  always_comb begin
    px_e = XS_W'(px_q);
    py_e = YS_W'(py_q);
    ox_e = XS_W'(ox_q[index_q*X_BITWIDTH +: X_BITWIDTH]);
    oy_e = YS_W'(oy_q[index_q*Y_BITWIDTH +: Y_BITWIDTH]);
    hit  = act_q[index_q]
         && (py_e < oy_e + OW_E) && (py_e + PW_E > oy_e)
         && (px_e < ox_e + OH_E) && (px_e + PH_E > ox_e);
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    px_d        = px_q;
    py_d        = py_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    act_d       = act_q;
    work_d      = work_q;
    hit_mask_d  = hit_mask_q;
    done_d      = 1'b0;
    collision_d = collision_q;

    if (bus.clear) begin
      collision_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          px_d    = bus.player_x;
          py_d    = bus.player_y;
          ox_d    = bus.obstacle_x;
          oy_d    = bus.obstacle_y;
          act_d   = bus.obstacle_active;
          index_d = '0;
          work_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        work_d[index_q] = hit;
        if (index_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      S_DONE: begin
        hit_mask_d = work_q;
        done_d     = 1'b1;
        // A hit in this scan wins over a simultaneous clear.
        if (|work_q) begin
          collision_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      act_q       <= '0;
      work_q      <= '0;
      hit_mask_q  <= '0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      px_q        <= px_d;
      py_q        <= py_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      act_q       <= act_d;
      work_q      <= work_d;
      hit_mask_q  <= hit_mask_d;
      done_q      <= done_d;
      collision_q <= collision_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hit_mask  = hit_mask_q;
  assign bus.collision = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_scheduler.sv
// ============================================================================
// Module   : tb_collision_scheduler
// Function : Directed self-checking bench for collision_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_collision_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 9;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  collision_scheduler_if #(.N_OBSTACLES(N), .X_BITWIDTH(XW), .Y_BITWIDTH(YW)) bus ();

  collision_scheduler #(
    .N_OBSTACLES    (N),
    .X_BITWIDTH     (XW),
    .Y_BITWIDTH     (YW),
    .PLAYER_WIDTH   (32),
    .PLAYER_HEIGHT  (50),
    .OBSTACLE_WIDTH (32),
    .OBSTACLE_HEIGHT(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input bit act);
    bus.obstacle_x[i*XW +: XW] = XW'(x);
    bus.obstacle_y[i*YW +: YW] = YW'(y);
    bus.obstacle_active[i]     = act;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // One frame scan; optional disturbances: move slot0 after the start edge,
  // pulse start mid-scan, or hold clear during the DONE cycle.
  task automatic do_scan(input string tag, input logic [3:0] exp_mask, input logic exp_col,
                         input bit move_slot0, input bit restart_mid, input bit clear_in_done);
    int cyc;
    int busy_cnt;
    int extra_done;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (move_slot0) set_slot(0, 250, 0, 1'b1);
    cyc = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      if (restart_mid && cyc == 2) bus.start = 1'b1;
      if (restart_mid && cyc == 3) bus.start = 1'b0;
      if (clear_in_done && cyc == 5) bus.clear = 1'b1;
      tick();
      cyc++;
    end
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(cyc - 1), 32'd5);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_hit_mask"}, 32'(bus.hit_mask), 32'(exp_mask));
    check({tag, "_collision"}, 32'(bus.collision), 32'(exp_col));
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) extra_done++;
    end
    check({tag, "_single_done"}, 32'(extra_done), 32'd0);
    check({tag, "_mask_hold"}, 32'(bus.hit_mask), 32'(exp_mask));
  endtask

  initial begin
    int stray;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.player_x = '0;
    bus.player_y = '0;
    bus.obstacle_x = '0;
    bus.obstacle_y = '0;
    bus.obstacle_active = '0;
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_mask", 32'(bus.hit_mask), 32'd0);
    check("reset_col", 32'(bus.collision), 32'd0);
    reset = 1'b1;
    tick();

    // Basic hit: slot0 overlaps, slot1 clear on x, slots 2-3 inactive
    bus.player_x = 8'd100;
    bus.player_y = 9'd100;
    set_slot(0, 120, 110, 1'b1);
    set_slot(1, 200, 300, 1'b1);
    set_slot(2, 120, 110, 1'b0);
    set_slot(3, 100, 100, 1'b0);
    do_scan("basic", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Sticky flag survives a scan without hits
    set_slot(0, 200, 300, 1'b1);
    do_scan("sticky", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    check("clear_col", 32'(bus.collision), 32'd0);
    check("clear_mask_kept", 32'(bus.hit_mask), 32'd0);

    // Touching edge on y is not a hit; one pixel inside is
    set_slot(0, 100, 132, 1'b1);
    do_scan("edge_touch", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    set_slot(0, 100, 131, 1'b1);
    do_scan("edge_in", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // py + width = 532 would wrap to 20 in a 9-bit sum
    bus.player_y = 9'd500;
    set_slot(0, 100, 131, 1'b0);
    set_slot(1, 200, 300, 1'b0);
    set_slot(2, 100, 490, 1'b1);
    do_scan("overflow", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // Inactive overlapping slot, then snapshot immune to later moves
    bus.player_y = 9'd100;
    set_slot(2, 100, 490, 1'b0);
    set_slot(0, 120, 110, 1'b0);
    do_scan("inactive", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    set_slot(0, 120, 110, 1'b1);
    do_scan("snapshot", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    check("clear2_col", 32'(bus.collision), 32'd0);

    // Clear held in the DONE cycle of a hit scan loses to the set
    set_slot(0, 120, 110, 1'b1);
    do_scan("clear_in_done", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);

    // Start pulsed mid-scan is ignored
    set_slot(0, 250, 0, 1'b1);
    do_scan("restart_ignored", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-scan: everything cleared, no done, next start accepted
    set_slot(0, 120, 110, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_col", 32'(bus.collision), 32'd0);
    stray = 0;
    repeat (3) begin
      tick();
      if (bus.done) stray++;
    end
    reset = 1'b1;
    repeat (6) begin
      tick();
      if (bus.done) stray++;
    end
    check("midrst_no_done", 32'(stray), 32'd0);
    check("midrst_mask", 32'(bus.hit_mask), 32'd0);
    do_scan("after_reset", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/collision_scheduler.md
# collision_scheduler

Time-multiplexed collision controller for the game datapath. On each frame tick it snapshots the player position and up to N obstacle positions, then checks the player against one obstacle per clock using a single shared bounding-box comparator. It produces a per-obstacle hit mask, a done pulse and a sticky game-over flag for the game-state logic. It sits between the obstacle position updaters and the game FSM, and replaces per-obstacle comparator instances.

## Interface
- N_OBSTACLES, 4: number of obstacle slots (1..16)
- X_BITWIDTH, 8: x coordinate width (player and obstacles)
- Y_BITWIDTH, 9: y coordinate width (player and obstacles)
- PLAYER_WIDTH, 32: player extent along y
- PLAYER_HEIGHT, 50: player extent along x
- OBSTACLE_WIDTH, 32: obstacle extent along y
- OBSTACLE_HEIGHT, 50: obstacle extent along x

Ports:
- clock  in  1  single system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame tick; sampled only in IDLE
- clear  in  1  clears sticky collision flag (new game)
- player_x  in  X_BITWIDTH  player x
- player_y  in  Y_BITWIDTH  player y
- obstacle_x  in  N_OBSTACLES*X_BITWIDTH  packed obstacle x; slot i at bits [i*X_BITWIDTH +: X_BITWIDTH]
- obstacle_y  in  N_OBSTACLES*Y_BITWIDTH  packed obstacle y; same packing
- obstacle_active  in  N_OBSTACLES  slot enable mask
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when results update
- hit_mask  out  N_OBSTACLES  per-slot overlap result of last completed scan
- collision  out  1  sticky: set when any completed scan has a hit

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: if start=1, latch player_x/y, all obstacle_x/y and obstacle_active into snapshot registers. Set index=0, clear the working mask, then go to SCAN. start is ignored in SCAN and DONE; there is no queuing.
- SCAN: each cycle evaluate slot[index] from the snapshot:
  - hit = active[index] && (py < oy + OBSTACLE_WIDTH) && (py + PLAYER_WIDTH > oy) && (px < ox + OBSTACLE_HEIGHT) && (px + PLAYER_HEIGHT > ox)
  - Write hit into working mask bit [index].
  - If index == N_OBSTACLES-1, go to DONE; otherwise index+1.
- DONE: hit_mask <= working mask; done=1 for this cycle; collision <= 1 if any working bit is set. Then go to IDLE.
- Arithmetic: every sum is computed one bit wider than its operand, plus enough bits for the extent parameter. Sums never wrap. Comparisons are unsigned, and all comparisons are strict, so touching edges are not a hit.
- Live input changes after the start cycle do not affect the scan in progress.
- clear: collision <= 0 on any cycle it is high, except in the DONE cycle with any hit, where the set takes priority. clear does not affect hit_mask or the FSM.
- busy = 1 in SCAN and DONE, 0 in IDLE.

## Timing
- Reset (async assert, any state): FSM=IDLE, index=0, snapshot and working mask=0, busy=0, done=0, hit_mask=0, collision=0. Reset mid-scan discards that scan, and no done pulse is issued.
- Outputs are registered except busy, which decodes directly from the state register.
- Latency: start sampled at edge E0 → SCAN cycles E1..EN → done high in the cycle after edge EN+1. hit_mask and collision are valid from that same edge. The total is N_OBSTACLES+1 cycles from start edge to done edge.
- Minimum start-to-start period is N_OBSTACLES+2 cycles. A start held high continuously re-triggers as soon as the FSM returns to IDLE.
- hit_mask holds its value between scans.

## Test plan
- Reset: hold reset=0 mid-scan, release → all outputs 0, FSM accepts the next start immediately. No stray done pulse.
- Basic hit, N=4: player (100,100); slot0 (120,110), slot1 (200,300), slots 2–3 inactive; pulse start → done after exactly 5 cycles, hit_mask=4'b0001, collision=1, busy high for 5 cycles.
- Edge touch: player (100,100), slot0 at y=132, x=100, active → hit_mask=0 (132 > 132 false), collision stays 0. Repeat with y=131 → hit_mask=4'b0001.
- Width overflow: player y=500, slot2 y=490, x equal, active → hit_mask=4'b0100. A truncated 9-bit sum would miss this.
- Snapshot and inactive slot: start with slot0 overlapping but obstacle_active[0]=0 → no hit. Start again with slot0 active, then move slot0 far away on the cycle after start → hit_mask[0]=1.
- Sticky/clear: after a hit, scan with no hits → hit_mask=0, collision=1. Pulse clear → collision=0. Assert clear in the DONE cycle of a hit scan → collision=1. Pulse start during SCAN → ignored, still exactly one done.
